// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard/stall controller for the 5-stage MIPS core.
//   Resolves forwarding, load-use/branch/jr stalls, the multi-cycle divider
//   handshake (with watchdog), SRAM wait states and exception flushes.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rsD, rtD, branchD, jrD, jalrD, jumpD          decode-stage operands/control flow
//   rsE, rtE, writeregE, regwriteE, memtoregE     execute-stage operands/writeback
//   divE, div_readyE                 divide in E / divider result valid
//   writeregM, regwriteM, memtoregM  memory-stage writeback
//   writeregW, regwriteW             writeback-stage writeback
//   i_stall, d_stall, excM           SRAM not ready (inst/data), exception in M
//   forwardaD/bD, forwardaE/bE       forward selects (E: 10 = M, 01 = W)
//   stallF/D/E/M, flushD/E/M/W       pipeline register controls
//   div_startE, div_abort, div_err   divider start/cancel pulses, sticky watchdog flag
//   stall_cnt                        saturating count of cycles with stallF
module hazard_ctrl_mc #(
    parameter int REG_AW   = 5,
    parameter int DIV_MAXC = 40,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              jalrD,
    input  logic              jumpD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic              div_readyE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              i_stall,
    input  logic              d_stall,
    input  logic              excM,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_startE,
    output logic              div_abort,
    output logic              div_err,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic {DIV_IDLE, DIV_BUSY} divState_e;
    localparam int WD_W = $clog2(DIV_MAXC + 1);

    divState_e       divState, divNext;
    logic [WD_W-1:0] wdCnt, wdNext;
    logic            divStall, abortReq, errSet;
    logic            lwStall, brStall, jrStall;

    assign forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
    assign forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);
    assign forwardaE = (rsE == '0) ? 2'b00 :
                       (regwriteM && writeregM == rsE) ? 2'b10 :
                       (regwriteW && writeregW == rsE) ? 2'b01 : 2'b00;
    assign forwardbE = (rtE == '0) ? 2'b00 :
                       (regwriteM && writeregM == rtE) ? 2'b10 :
                       (regwriteW && writeregW == rtE) ? 2'b01 : 2'b00;

    assign lwStall = memtoregE && (rtE == rsD || rtE == rtD);
    assign brStall = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                                 (memtoregM && (writeregM == rsD || writeregM == rtD)));
    assign jrStall = (jrD || jalrD) && ((regwriteE && writeregE == rsD) ||
                                        (memtoregM && writeregM == rsD));

    // Divider handshake: an exception cancels the division even when the
    // result arrives in the same cycle; the watchdog only fires without ready.
    always_comb begin
        divNext    = divState;
        wdNext     = wdCnt;
        divStall   = 1'b0;
        div_startE = 1'b0;
        abortReq   = 1'b0;
        errSet     = 1'b0;
        if (divState == DIV_IDLE) begin
            if (divE && !excM) begin
                div_startE = 1'b1;
                divStall   = 1'b1;
                divNext    = DIV_BUSY;
                wdNext     = '0;
            end
        end else begin
            divStall = !div_readyE;
            if (excM) begin
                abortReq = 1'b1;
                divNext  = DIV_IDLE;
            end else if (!div_readyE && wdCnt == WD_W'(DIV_MAXC - 1)) begin
                abortReq = 1'b1;
                errSet   = 1'b1;
                divNext  = DIV_IDLE;
            end else if (div_readyE) begin
                divNext = DIV_IDLE;
            end else begin
                wdNext = wdCnt + 1'b1;
            end
        end
    end

    // Reset mid-division returns the FSM to idle silently.
    assign div_abort = abortReq && !rst;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (excM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (d_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwStall || brStall || jrStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (i_stall) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end else begin
            flushE = jumpD || jrD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divState  <= DIV_IDLE;
            wdCnt     <= '0;
            div_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            divState <= divNext;
            wdCnt    <= wdNext;
            if (errSet) div_err <= 1'b1;
            if (stallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed and randomized check of hazard_ctrl_mc against a behavioural model.
module tb_hazard_ctrl_mc;
    localparam int AW = 5, MAXC = 40, CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, branchD, jrD, jalrD, jumpD, regwriteE, memtoregE, divE, div_readyE;
    logic regwriteM, memtoregM, regwriteW, i_stall, d_stall, excM;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic forwardaD, forwardbD, stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM, flushW, div_startE, div_abort, div_err;
    logic [1:0] forwardaE, forwardbE;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl_mc #(.REG_AW(AW), .DIV_MAXC(MAXC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .jalrD(jalrD), .jumpD(jumpD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE), .div_readyE(div_readyE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW), .i_stall(i_stall), .d_stall(d_stall),
        .excM(excM), .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
        .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_startE(div_startE), .div_abort(div_abort), .div_err(div_err), .stall_cnt(stall_cnt)
    );

    int vectors = 0, miscompares = 0;

    // Model: whether a division is outstanding, how many busy cycles have elapsed,
    // the sticky error and the stall count as plain integers.
    bit mValid = 0, mBusy = 0, mErr = 0;
    int mCycles = 0, mCnt = 0;
    bit sStart, sTimeout, sStallF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdE(input logic [AW-1:0] r);
        if (r == 0) return 2'b00;
        if (regwriteM && writeregM == r) return 2'b10;
        if (regwriteW && writeregW == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic evalCycle();
        bit lw, br, jr, dstall, abort;
        logic [7:0] e;
        #2;
        if (mValid) begin
            lw = memtoregE && (rtE == rsD || rtE == rtD);
            br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                             (memtoregM && (writeregM == rsD || writeregM == rtD)));
            jr = (jrD || jalrD) && ((regwriteE && writeregE == rsD) || (memtoregM && writeregM == rsD));
            sStart = !mBusy && divE && !excM;
            sTimeout = mBusy && !excM && !div_readyE && mCycles == MAXC - 1;
            abort = !rst && mBusy && (excM || sTimeout);
            dstall = mBusy ? !div_readyE : sStart;
            if (excM) e = 8'b0000_1110;
            else if (d_stall) e = 8'b1111_0001;
            else if (dstall) e = 8'b1110_0010;
            else if (lw || br || jr) e = 8'b1100_0100;
            else if (i_stall) e = 8'b1000_1000;
            else e = {5'b0, jumpD || jrD, 2'b0};
            sStallF = e[7];
            chk("stallFDEM_flushDEMW", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}, e);
            chk("forwardaD", forwardaD, rsD != 0 && regwriteM && writeregM == rsD);
            chk("forwardbD", forwardbD, rtD != 0 && regwriteM && writeregM == rtD);
            chk("forwardaE", forwardaE, fwdE(rsE));
            chk("forwardbE", forwardbE, fwdE(rtE));
            chk("div_startE", div_startE, sStart);
            chk("div_abort", div_abort, abort);
            chk("div_err", div_err, mErr);
            chk("stall_cnt", stall_cnt, mCnt);
        end
    endtask

    task automatic advance();
        if (rst) begin
            mValid = 1; mBusy = 0; mCycles = 0; mErr = 0; mCnt = 0;
        end else if (mValid) begin
            if (sStallF && mCnt < 2**CW - 1) mCnt++;
            if (sTimeout) mErr = 1;
            if (sStart) begin
                mBusy = 1; mCycles = 0;
            end else if (mBusy) begin
                if (excM || sTimeout || div_readyE) mBusy = 0;
                else mCycles++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            evalCycle();
            advance();
        end
    endtask

    task automatic clr();
        {branchD, jrD, jalrD, jumpD, regwriteE, memtoregE, divE, div_readyE} = '0;
        {regwriteM, memtoregM, regwriteW, i_stall, d_stall, excM} = '0;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    endtask

    initial begin
        int nStart, nStallE, abortAt;
        rst = 1; clr();
        run(2);
        rst = 0;
        evalCycle();
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset div_err", div_err, 0);
        advance();

        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        evalCycle(); chk("fwd M beats W", forwardaE, 2'b10); advance();
        rsE = 0;
        evalCycle(); chk("fwd reg0", forwardaE, 2'b00); advance();
        clr(); rsE = 4; writeregW = 4; regwriteW = 1;
        evalCycle(); chk("fwd W", forwardaE, 2'b01); advance();

        clr(); memtoregE = 1; rtE = 5; rsD = 5;
        evalCycle(); chk("lwstall", {stallF, stallD, flushE}, 3'b111); advance();
        clr();
        evalCycle(); chk("lwstall released", stallF, 0); chk("lwstall cnt", stall_cnt, 1); advance();

        nStart = 0; nStallE = 0;
        for (int i = 0; i <= 10; i++) begin
            divE = 1; div_readyE = (i == 10);
            evalCycle(); nStart += int'(div_startE); nStallE += int'(stallE); advance();
        end
        clr();
        evalCycle(); chk("div starts", nStart, 1); chk("div stallE cycles", nStallE, 10); advance();

        abortAt = -1;
        for (int i = 0; i < 46; i++) begin
            divE = (abortAt < 0);
            evalCycle(); if (div_abort && abortAt < 0) abortAt = i; advance();
        end
        chk("watchdog abort cycle", abortAt, 40);
        evalCycle(); chk("watchdog err", div_err, 1); chk("watchdog released", stallF, 0); advance();
        for (int i = 0; i < 3; i++) begin
            divE = 1; div_readyE = (i == 2); run(1);
        end
        clr();
        evalCycle(); chk("err sticky", div_err, 1); advance();

        for (int i = 0; i < 3; i++) begin divE = 1; run(1); end
        excM = 1; d_stall = 1;
        evalCycle();
        chk("exc flush", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}, 8'b0000_1110);
        chk("exc abort", div_abort, 1);
        advance();
        clr();
        evalCycle(); chk("exc idle", stallE, 0); advance();

        divE = 1; run(2);
        rst = 1; excM = 1;
        evalCycle(); chk("rst no abort", div_abort, 0); advance();
        rst = 0; clr();
        evalCycle(); chk("rst idle", stallE, 0); chk("rst err clr", div_err, 0); advance();

        d_stall = 1; i_stall = 1;
        run(14);
        evalCycle(); chk("cnt 14", stall_cnt, 14); advance();
        run(9);
        evalCycle(); chk("cnt sat", stall_cnt, 15); advance();
        rst = 1; run(1); rst = 0;
        evalCycle(); chk("cnt rst", stall_cnt, 0); advance();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
            rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
            writeregE = AW'($urandom_range(0, 3)); writeregM = AW'($urandom_range(0, 3));
            writeregW = AW'($urandom_range(0, 3));
            branchD = ($urandom_range(0, 4) == 0); jrD = ($urandom_range(0, 6) == 0);
            jalrD = ($urandom_range(0, 6) == 0); jumpD = ($urandom_range(0, 4) == 0);
            regwriteE = $urandom_range(0, 1) == 1; memtoregE = ($urandom_range(0, 3) == 0);
            regwriteM = $urandom_range(0, 1) == 1; memtoregM = ($urandom_range(0, 3) == 0);
            regwriteW = $urandom_range(0, 1) == 1;
            divE = ($urandom_range(0, 5) == 0); div_readyE = ($urandom_range(0, 3) == 0);
            i_stall = ($urandom_range(0, 4) == 0); d_stall = ($urandom_range(0, 6) == 0);
            excM = ($urandom_range(0, 19) == 0);
            run(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
